// File: rtl/spi_slave_reg_if_pkg.sv
// spi_reg_pkg: shared types and constants for the SPI register front end.
//   - read/write opcode values
//   - FSM state encoding
//   - register index type and an opcode decoder
package spi_reg_pkg;

   localparam logic [7:0] OP_WR_REG0 = 8'h01;
   localparam logic [7:0] OP_WR_REG1 = 8'h11;
   localparam logic [7:0] OP_WR_REG2 = 8'h20;
   localparam logic [7:0] OP_WR_REG3 = 8'h30;
   localparam logic [7:0] OP_RD_REG0 = 8'h05;
   localparam logic [7:0] OP_RD_REG1 = 8'h07;
   localparam logic [7:0] OP_RD_REG2 = 8'h21;
   localparam logic [7:0] OP_RD_REG3 = 8'h31;

   typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DISCARD} spi_reg_state_t;

   typedef logic [1:0] reg_idx_t;

   typedef struct packed {
      logic     valid;  // opcode is one of the eight known values
      logic     wr;     // 1 = write, 0 = read
      reg_idx_t idx;
   } op_dec_t;

   function automatic op_dec_t decode_op(input logic [7:0] op);
      op_dec_t d;
      d = '0;
      case (op)
         OP_WR_REG0: d = {1'b1, 1'b1, 2'd0};
         OP_WR_REG1: d = {1'b1, 1'b1, 2'd1};
         OP_WR_REG2: d = {1'b1, 1'b1, 2'd2};
         OP_WR_REG3: d = {1'b1, 1'b1, 2'd3};
         OP_RD_REG0: d = {1'b1, 1'b0, 2'd0};
         OP_RD_REG1: d = {1'b1, 1'b0, 2'd1};
         OP_RD_REG2: d = {1'b1, 1'b0, 2'd2};
         OP_RD_REG3: d = {1'b1, 1'b0, 2'd3};
         default:    d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/spi_slave_reg_if_sync.sv
// spi_slave_sync: brings the SPI pad signals into the clk domain.
//   clk, rst_n      : system clock, async active-low reset
//   sck, csn, sdi   : raw pad inputs
//   sck_rise/fall   : one-cycle SCK edge strobes
//   csn_s, sdi_s    : synchronized CSN and SDI
// SDI goes through the same depth as SCK, so sdi_s is the bit the master
// presented at the SCK rise when sck_rise is high.
module spi_slave_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic sck,
   input  logic csn,
   input  logic sdi,
   output logic sck_rise,
   output logic sck_fall,
   output logic csn_s,
   output logic sdi_s
);

   logic [1:0] sck_ff, csn_ff, sdi_ff;
   logic       sck_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_ff <= 2'b00;
         csn_ff <= 2'b11;   // deselected while in reset
         sdi_ff <= 2'b00;
         sck_d  <= 1'b0;
      end else begin
         sck_ff <= {sck_ff[0], sck};
         csn_ff <= {csn_ff[0], csn};
         sdi_ff <= {sdi_ff[0], sdi};
         sck_d  <= sck_ff[1];
      end
   end

   assign sck_rise = sck_ff[1] & ~sck_d;
   assign sck_fall = ~sck_ff[1] & sck_d;
   assign csn_s    = csn_ff[1];
   assign sdi_s    = sdi_ff[1];

endmodule

// File: rtl/spi_slave_reg_if.sv
// spi_slave_reg_if: SPI mode-0 slave decoding one command byte, then
// writing one data byte into a config register or shifting one out.
//   clk, rst_n            : system clock (>= 8x SCK), async active-low reset
//   spi_sck/csn/sdi_i     : SPI pads in
//   spi_sdo_o/_oe_o       : SPI data out and its pad enable
//   reg0_o..reg3_o        : mode, dummy cycles, wrap length low/high
//   reg_wr_o/_addr_o      : one-cycle write commit strobe and index
//   cmd_err_o             : one-cycle strobe on an unknown opcode
module spi_slave_reg_if
   import spi_reg_pkg::*;
#(
   parameter logic [7:0] REG0_RST = 8'h00,
   parameter logic [7:0] REG1_RST = 8'd31,
   parameter logic [7:0] REG2_RST = 8'h00,
   parameter logic [7:0] REG3_RST = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spi_sck_i,
   input  logic       spi_csn_i,
   input  logic       spi_sdi_i,
   output logic       spi_sdo_o,
   output logic       spi_sdo_oe_o,
   output logic [7:0] reg0_o,
   output logic [7:0] reg1_o,
   output logic [7:0] reg2_o,
   output logic [7:0] reg3_o,
   output logic       reg_wr_o,
   output logic [1:0] reg_wr_addr_o,
   output logic       cmd_err_o
);

   logic            sck_rise, sck_fall, csn_s, sdi_s;
   spi_reg_state_t  state, state_nxt;
   logic [2:0]      bit_cnt;
   logic [6:0]      shift_in;
   logic [7:0]      shift_out, rx_byte;
   logic [3:0][7:0] regs;
   reg_idx_t        sel;
   logic            csn_prev, byte_done, in_xfer;
   op_dec_t         dec;

   spi_slave_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .sck      (spi_sck_i),
      .csn      (spi_csn_i),
      .sdi      (spi_sdi_i),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall),
      .csn_s    (csn_s),
      .sdi_s    (sdi_s)
   );

   // Full byte including the bit arriving on this rise.
   assign rx_byte   = {shift_in, sdi_s};
   // Counter wrap 7->0 marks the end of a byte.
   assign byte_done = sck_rise && (bit_cnt == 3'd7);
   assign dec       = decode_op(rx_byte);
   assign in_xfer   = (state == CMD) || (state == WDATA) || (state == RDATA);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (csn_s) begin
         state_nxt = IDLE;   // deselect wins over any same-cycle byte end
      end else begin
         case (state)
            IDLE:    if (csn_prev) state_nxt = CMD;
            CMD:     if (byte_done)
                        state_nxt = !dec.valid ? DISCARD : (dec.wr ? WDATA : RDATA);
            WDATA:   if (byte_done) state_nxt = DISCARD;
            RDATA:   if (byte_done) state_nxt = DISCARD;
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs          <= {REG3_RST, REG2_RST, REG1_RST, REG0_RST};
         bit_cnt       <= 3'd0;
         shift_in      <= 7'd0;
         shift_out     <= 8'd0;
         sel           <= 2'd0;
         csn_prev      <= 1'b1;
         spi_sdo_o     <= 1'b0;
         spi_sdo_oe_o  <= 1'b0;
         reg_wr_o      <= 1'b0;
         reg_wr_addr_o <= 2'd0;
         cmd_err_o     <= 1'b0;
      end else begin
         csn_prev  <= csn_s;
         reg_wr_o  <= 1'b0;
         cmd_err_o <= 1'b0;
         if (csn_s) begin
            bit_cnt      <= 3'd0;
            spi_sdo_oe_o <= 1'b0;
         end else begin
            if (sck_rise && in_xfer) begin
               bit_cnt  <= bit_cnt + 3'd1;
               shift_in <= rx_byte[6:0];
            end
            case (state)
               CMD: if (byte_done) begin
                  sel <= dec.idx;
                  if (!dec.valid)  cmd_err_o <= 1'b1;
                  else if (!dec.wr) shift_out <= regs[dec.idx];  // read snapshot
               end
               WDATA: if (byte_done) begin
                  regs[sel]     <= rx_byte;
                  reg_wr_o      <= 1'b1;
                  reg_wr_addr_o <= sel;
               end
               RDATA: begin
                  // First fall (end of the 8th command bit) presents bit 7.
                  if (sck_fall) begin
                     spi_sdo_oe_o <= 1'b1;
                     spi_sdo_o    <= shift_out[7];
                     shift_out    <= {shift_out[6:0], 1'b0};
                  end
                  if (byte_done) spi_sdo_oe_o <= 1'b0;
               end
               default: spi_sdo_oe_o <= 1'b0;
            endcase
         end
      end
   end

   assign reg0_o = regs[0];
   assign reg1_o = regs[1];
   assign reg2_o = regs[2];
   assign reg3_o = regs[3];

endmodule

// File: tb/tb_spi_slave_reg_if.sv
module tb_spi_slave_reg_if;

   localparam int HALF = 6;   // SCK half period in clk cycles

   logic       clk, rst_n;
   logic       spi_sck_i, spi_csn_i, spi_sdi_i;
   logic       spi_sdo_o, spi_sdo_oe_o;
   logic [7:0] reg0_o, reg1_o, reg2_o, reg3_o;
   logic       reg_wr_o, cmd_err_o;
   logic [1:0] reg_wr_addr_o;
   logic [3:0][7:0] rego;

   spi_slave_reg_if dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .spi_sck_i     (spi_sck_i),
      .spi_csn_i     (spi_csn_i),
      .spi_sdi_i     (spi_sdi_i),
      .spi_sdo_o     (spi_sdo_o),
      .spi_sdo_oe_o  (spi_sdo_oe_o),
      .reg0_o        (reg0_o),
      .reg1_o        (reg1_o),
      .reg2_o        (reg2_o),
      .reg3_o        (reg3_o),
      .reg_wr_o      (reg_wr_o),
      .reg_wr_addr_o (reg_wr_addr_o),
      .cmd_err_o     (cmd_err_o)
   );

   assign rego = {reg3_o, reg2_o, reg1_o, reg0_o};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model: each register holds old value until eff_cyc, new value after.
   logic [7:0] m_old [4];
   logic [7:0] m_new [4];
   int         eff_cyc [4];
   int         wr_cyc, wr_idx, err_cyc, oe_lo, oe_hi;
   bit         chk_en = 1'b0;

   typedef struct {
      string      name;
      logic [7:0] act;
      logic [7:0] exp;
   } lit_t;
   lit_t lit_q[$];

   int checks = 0;
   int failures = 0;

   function automatic logic [7:0] mcur(input int i);
      return (cyc >= eff_cyc[i]) ? m_new[i] : m_old[i];
   endfunction

   task automatic m_reset();
      logic [7:0] rv [4];
      rv = '{8'h00, 8'd31, 8'h00, 8'h00};
      for (int i = 0; i < 4; i++) begin
         m_old[i] = rv[i]; m_new[i] = rv[i]; eff_cyc[i] = 0;
      end
      wr_cyc = -10; wr_idx = 0; err_cyc = -10; oe_lo = 0; oe_hi = 0;
   endtask

   task automatic post(input string n, input logic [7:0] a, input logic [7:0] e);
      lit_t l;
      l.name = n; l.act = a; l.exp = e;
      lit_q.push_back(l);
   endtask

   task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at cycle %0d", n, a, e, cyc);
      end
   endtask

   // Single compare process: per-cycle model checks plus posted literals.
   always @(negedge clk) begin
      if (chk_en) begin
         lit_t l;
         bit   oe_ok;
         for (int i = 0; i < 4; i++) chk($sformatf("reg%0d", i), rego[i], mcur(i));
         chk("reg_wr", {7'd0, reg_wr_o}, {7'd0, cyc == wr_cyc});
         if (cyc == wr_cyc) chk("reg_wr_addr", {6'd0, reg_wr_addr_o}, wr_idx[7:0]);
         chk("cmd_err", {7'd0, cmd_err_o}, {7'd0, cyc == err_cyc});
         oe_ok = (cyc >= oe_lo) && (cyc < oe_hi);
         chk("oe_outside_read", {7'd0, spi_sdo_oe_o & ~oe_ok}, 8'd0);
         while (lit_q.size() > 0) begin
            l = lit_q.pop_front();
            chk(l.name, l.act, l.exp);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tb_dec(input logic [7:0] op, output bit v, output bit w, output int idx);
      v = 1'b1; w = 1'b1; idx = 0;
      case (op)
         8'h01: idx = 0;
         8'h11: idx = 1;
         8'h20: idx = 2;
         8'h30: idx = 3;
         8'h05: begin w = 1'b0; idx = 0; end
         8'h07: begin w = 1'b0; idx = 1; end
         8'h21: begin w = 1'b0; idx = 2; end
         8'h31: begin w = 1'b0; idx = 3; end
         default: v = 1'b0;
      endcase
   endtask

   // Present a bit, wait, sample SDO, raise SCK. Returns with SCK high.
   task automatic rise(input logic b, output logic r, output logic oe_s);
      spi_sdi_i = b;
      tick(HALF);
      r    = spi_sdo_o;
      oe_s = spi_sdo_oe_o;
      spi_sck_i = 1'b1;
   endtask

   task automatic fall();
      tick(HALF);
      spi_sck_i = 1'b0;
   endtask

   task automatic spi_txn(input logic [7:0] op, input logic [7:0] dat, input int ndat,
                          input bit end_cs, output logic [7:0] rx);
      bit v, w;
      int idx;
      logic r, oe_s;
      logic [7:0] snap;
      rx = 8'h00; snap = 8'h00;
      tb_dec(op, v, w, idx);
      spi_csn_i = 1'b0;
      tick(HALF);
      for (int i = 7; i >= 0; i--) begin
         rise(op[i], r, oe_s);
         if (i == 0) begin
            if (!v) err_cyc = cyc + 3;
            else if (!w) begin snap = mcur(idx); oe_lo = cyc; oe_hi = 32'h3fff_ffff; end
         end
         fall();
      end
      for (int j = 0; j < ndat; j++) begin
         rise(dat[7-j], r, oe_s);
         if (v && !w) begin
            rx[7-j] = r;
            post("rd_oe", {7'd0, oe_s}, 8'h01);
         end
         if (j == 7) begin
            if (v && w) begin
               m_old[idx] = mcur(idx); m_new[idx] = dat; eff_cyc[idx] = cyc + 3;
               wr_cyc = cyc + 3; wr_idx = idx;
            end
            if (v && !w) oe_hi = cyc + 3;
         end
         fall();
      end
      if (end_cs) begin
         tick(HALF);
         spi_csn_i = 1'b1;
         if (v && !w && ndat < 8) oe_hi = cyc + 3;
         tick(2 * HALF);
      end
      if (v && !w && ndat == 8) post("rd_model", rx, snap);
   endtask

   initial begin
      logic [7:0] rx;
      rst_n = 1'b1; spi_sck_i = 1'b0; spi_csn_i = 1'b1; spi_sdi_i = 1'b0;
      m_reset();
      chk_en = 1'b1;
      #2 rst_n = 1'b0;
      tick(4);
      rst_n = 1'b1;
      tick(20);
      post("idle_reg1", reg1_o, 8'd31);
      post("idle_reg0", reg0_o, 8'h00);

      spi_txn(8'h11, 8'd31, 8, 1'b1, rx);
      spi_txn(8'h07, 8'h00, 8, 1'b1, rx);
      post("rd_07", rx, 8'h1F);

      spi_txn(8'h01, 8'hA5, 8, 1'b1, rx);
      post("wr_reg0", reg0_o, 8'hA5);
      spi_txn(8'h05, 8'h00, 8, 1'b1, rx);
      post("rd_05", rx, 8'hA5);

      spi_txn(8'hAA, 8'h55, 8, 1'b1, rx);
      post("err_reg0", reg0_o, 8'hA5);
      post("err_reg1", reg1_o, 8'd31);

      spi_txn(8'h20, 8'h3C, 4, 1'b1, rx);
      post("part_reg2", reg2_o, 8'h00);
      spi_txn(8'h20, 8'h3C, 8, 1'b1, rx);
      post("wr_reg2", reg2_o, 8'h3C);
      spi_txn(8'h21, 8'h00, 8, 1'b1, rx);
      post("rd_21", rx, 8'h3C);

      spi_txn(8'h30, 8'hC3, 8, 1'b1, rx);
      spi_txn(8'h31, 8'h00, 8, 1'b1, rx);
      post("rd_31", rx, 8'hC3);

      // Reset in the middle of a read's data phase.
      spi_txn(8'h07, 8'h00, 4, 1'b0, rx);
      post("rd_part", rx, 8'h10);
      tick(2);
      #2 rst_n = 1'b0;
      m_reset();
      #1;
      post("rst_oe", {7'd0, spi_sdo_oe_o}, 8'h00);
      post("rst_reg1", reg1_o, 8'd31);
      post("rst_reg0", reg0_o, 8'h00);
      spi_csn_i = 1'b1;
      tick(4);
      rst_n = 1'b1;
      tick(2 * HALF);
      spi_txn(8'h07, 8'h00, 8, 1'b1, rx);
      post("rd_07_after_rst", rx, 8'h1F);

      tick(5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
